// File: rtl/recorder_pkg.sv
// ============================================================================
// recorder_pkg : shared state, speed and key-decode types for the recorder.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package recorder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd1,
    PLAY   = 3'd2,
    RECORD = 3'd3,
    PAUSE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FAST   = 2'd1,
    SLOW   = 2'd2
  } spd_stat_t;

  typedef enum logic [2:0] {
    K_NONE   = 3'd0,
    K_STOP   = 3'd1,
    K_PAUSE  = 3'd2,
    K_RECORD = 3'd3,
    K_PLAY   = 3'd4,
    K_FASTER = 3'd5,
    K_SLOWER = 3'd6
  } key_t;

  localparam logic [3:0] SPEED_MIN = 4'd1;
  localparam logic [3:0] SPEED_MAX = 4'd8;

  // Only the highest-priority pulse survives a cycle; the rest are dropped.
  function automatic key_t key_sel(input logic stop, input logic pause,
                                   input logic rec, input logic play,
                                   input logic faster, input logic slower);
    if (stop)   return K_STOP;
    if (pause)  return K_PAUSE;
    if (rec)    return K_RECORD;
    if (play)   return K_PLAY;
    if (faster) return K_FASTER;
    if (slower) return K_SLOWER;
    return K_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/recorder_ctrl_sec_prescaler.sv
// ============================================================================
// sec_prescaler : divides the clock down to a one-cycle tick per second.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sec_prescaler #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            c_CW   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_PER_SEC - 1);

  logic [c_CW-1:0] cnt_q, cnt_d;

  // Tick is independent of i_clr so the parent can derive i_clr from o_tick paths.
  assign o_tick = i_en && (cnt_q == c_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)       cnt_d = '0;
    else if (i_en)   cnt_d = o_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/recorder_ctrl.sv
// ============================================================================
// recorder_ctrl : recorder mode FSM, seconds timer, playback speed, rec length.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module recorder_ctrl
  import recorder_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int MAX_SEC     = 31
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_record,
  input  logic       i_key_play,
  input  logic       i_key_pause,
  input  logic       i_key_stop,
  input  logic       i_key_faster,
  input  logic       i_key_slower,
  output logic [2:0] o_state,
  output logic [4:0] o_timer,
  output logic [1:0] o_speed_stat,
  output logic [3:0] o_speed,
  output logic       o_rec_en,
  output logic       o_play_en
);

  state_t     state_q, state_d, resume_q, resume_d;
  spd_stat_t  stat_q, stat_d;
  logic [4:0] timer_q, timer_d, rec_len_q, rec_len_d;
  logic [3:0] speed_q, speed_d;
  logic [2:0] slow_cnt_q, slow_cnt_d;
  logic       rec_en_q, play_en_q;
  logic       tick, pre_clr, step_ok;
  logic [5:0] sum;
  key_t       key;

  sec_prescaler #(.CLK_PER_SEC(CLK_PER_SEC)) u_presc (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   ((state_q == PLAY) || (state_q == RECORD)),
    .i_clr  (pre_clr),
    .o_tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    timer_d    = timer_q;
    rec_len_d  = rec_len_q;
    stat_d     = stat_q;
    speed_d    = speed_q;
    slow_cnt_d = slow_cnt_q;
    pre_clr    = 1'b0;
    step_ok    = 1'b0;
    sum        = {1'b0, timer_q} + 6'd1;
    key        = key_sel(i_key_stop, i_key_pause, i_key_record, i_key_play,
                         i_key_faster, i_key_slower);

    case (state_q)
      IDLE: begin
        if (key == K_RECORD) begin
          state_d = RECORD;
          timer_d = '0;
          pre_clr = 1'b1;
        end else if (key == K_PLAY && rec_len_q != 5'd0) begin
          state_d    = PLAY;
          timer_d    = '0;
          pre_clr    = 1'b1;
          slow_cnt_d = '0;
        end
      end
      RECORD: begin
        if (key == K_STOP) begin
          state_d   = IDLE;
          rec_len_d = timer_q;
          timer_d   = '0;
        end else if (key == K_PAUSE) begin
          state_d  = PAUSE;
          resume_d = RECORD;
        end else if (tick) begin
          if (sum == 6'(MAX_SEC)) begin
            state_d   = IDLE;
            rec_len_d = 5'(MAX_SEC);
            timer_d   = '0;
          end else begin
            timer_d = sum[4:0];
          end
        end
      end
      PLAY: begin
        if (key == K_STOP) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (key == K_PAUSE) begin
          state_d  = PAUSE;
          resume_d = PLAY;
        end else if (tick) begin
          case (stat_q)
            FAST: begin
              sum = {1'b0, timer_q} + {2'b00, speed_q};
              if (sum > {1'b0, rec_len_q}) sum = {1'b0, rec_len_q};
              step_ok = 1'b1;
            end
            SLOW: begin
              if ({1'b0, slow_cnt_q} == speed_q - 4'd1) begin
                step_ok    = 1'b1;
                slow_cnt_d = '0;
              end else begin
                slow_cnt_d = slow_cnt_q + 3'd1;
              end
            end
            default: step_ok = 1'b1;
          endcase
          if (step_ok) begin
            if (sum >= {1'b0, rec_len_q}) begin
              state_d = IDLE;
              timer_d = '0;
            end else begin
              timer_d = sum[4:0];
            end
          end
        end
      end
      PAUSE: begin
        if (key == K_STOP) begin
          state_d = IDLE;
          timer_d = '0;
          if (resume_q == RECORD) rec_len_d = timer_q;
        end else if (key == K_PAUSE || key == K_PLAY) begin
          state_d = resume_q;
          if (resume_q == PLAY) slow_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Speed keys are the lowest priority, so they only ever see K_FASTER/K_SLOWER alone.
    if (state_q != RECORD && (key == K_FASTER || key == K_SLOWER)) begin
      slow_cnt_d = '0;
      if (key == K_FASTER) begin
        case (stat_q)
          NORMAL: begin stat_d = FAST; speed_d = 4'd2; end
          FAST:   if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
          default: begin
            if (speed_q == 4'd2) begin stat_d = NORMAL; speed_d = SPEED_MIN; end
            else speed_d = speed_q - 4'd1;
          end
        endcase
      end else begin
        case (stat_q)
          NORMAL: begin stat_d = SLOW; speed_d = 4'd2; end
          SLOW:   if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
          default: begin
            if (speed_q == 4'd2) begin stat_d = NORMAL; speed_d = SPEED_MIN; end
            else speed_d = speed_q - 4'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      resume_q   <= IDLE;
      timer_q    <= '0;
      rec_len_q  <= '0;
      stat_q     <= NORMAL;
      speed_q    <= SPEED_MIN;
      slow_cnt_q <= '0;
      rec_en_q   <= 1'b0;
      play_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      timer_q    <= timer_d;
      rec_len_q  <= rec_len_d;
      stat_q     <= stat_d;
      speed_q    <= speed_d;
      slow_cnt_q <= slow_cnt_d;
      rec_en_q   <= (state_d == RECORD);
      play_en_q  <= (state_d == PLAY);
    end
  end

  assign o_state      = state_q;
  assign o_timer      = timer_q;
  assign o_speed_stat = stat_q;
  assign o_speed      = speed_q;
  assign o_rec_en     = rec_en_q;
  assign o_play_en    = play_en_q;

endmodule

`default_nettype wire

// File: tb/tb_recorder_ctrl.sv
// ============================================================================
// tb_recorder_ctrl : scoreboard bench for recorder_ctrl with a reference model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_recorder_ctrl;

  localparam int CPS = 10;
  localparam int MAXS = 31;
  // key vector bit order: {stop, pause, record, play, faster, slower}
  localparam logic [5:0] KB_STOP = 6'b100000, KB_PAUSE = 6'b010000, KB_REC = 6'b001000;
  localparam logic [5:0] KB_PLAY = 6'b000100, KB_FAST  = 6'b000010, KB_SLOW = 6'b000001;

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] tm;
    logic [1:0] ss;
    logic [3:0] sp;
    logic       re;
    logic       pe;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic k_rec = 0, k_play = 0, k_pause = 0, k_stop = 0, k_fast = 0, k_slow = 0;
  logic [2:0] o_state;
  logic [4:0] o_timer;
  logic [1:0] o_speed_stat;
  logic [3:0] o_speed;
  logic       o_rec_en, o_play_en;

  int n_vec = 0;
  int n_err = 0;
  obs_t exp_q[$];

  // Reference model: mode 1..4, speed as a signed level (0 normal, +n fast, -n slow).
  int m_mode, m_timer, m_rec_len, m_resume, m_level, m_phase, m_slow;

  always #5 clk = ~clk;

  recorder_ctrl #(.CLK_PER_SEC(CPS), .MAX_SEC(MAXS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_key_record(k_rec), .i_key_play(k_play), .i_key_pause(k_pause),
    .i_key_stop(k_stop), .i_key_faster(k_fast), .i_key_slower(k_slow),
    .o_state(o_state), .o_timer(o_timer), .o_speed_stat(o_speed_stat),
    .o_speed(o_speed), .o_rec_en(o_rec_en), .o_play_en(o_play_en)
  );

  function automatic obs_t model_obs();
    obs_t o;
    int mag;
    mag  = (m_level < 0) ? -m_level : m_level;
    o.st = 3'(m_mode);
    o.tm = 5'(m_timer);
    o.ss = (m_level == 0) ? 2'd0 : (m_level > 0 ? 2'd1 : 2'd2);
    o.sp = 4'(mag + 1);
    o.re = (m_mode == 3);
    o.pe = (m_mode == 2);
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 1; m_timer = 0; m_rec_len = 0; m_resume = 1;
    m_level = 0; m_phase = 0; m_slow = 0;
  endtask

  task automatic go_idle();
    m_mode  = 1;
    m_timer = 0;
  endtask

  task automatic model_step(input logic [5:0] k);
    int  top, old_mode, adv, spd;
    bit  tick;
    top = -1;
    for (int i = 5; i >= 0; i--) if (k[i] && top < 0) top = i;
    old_mode = m_mode;
    tick = (m_mode == 2 || m_mode == 3) && (m_phase == CPS - 1);
    if (m_mode == 2 || m_mode == 3) m_phase = (m_phase + 1) % CPS;
    spd = ((m_level < 0) ? -m_level : m_level) + 1;
    case (m_mode)
      1: begin
        if (top == 3) begin m_mode = 3; m_timer = 0; m_phase = 0; end
        else if (top == 2 && m_rec_len > 0) begin
          m_mode = 2; m_timer = 0; m_phase = 0; m_slow = 0;
        end
      end
      3: begin
        if (top == 5) begin m_rec_len = m_timer; go_idle(); end
        else if (top == 4) begin m_mode = 4; m_resume = 3; end
        else if (tick) begin
          m_timer++;
          if (m_timer == MAXS) begin m_rec_len = MAXS; go_idle(); end
        end
      end
      2: begin
        if (top == 5) go_idle();
        else if (top == 4) begin m_mode = 4; m_resume = 2; end
        else if (tick) begin
          adv = 1;
          if (m_level > 0) begin
            adv = (m_timer + spd > m_rec_len) ? m_rec_len - m_timer : spd;
          end else if (m_level < 0) begin
            m_slow++;
            if (m_slow == spd) m_slow = 0;
            else adv = 0;
          end
          if (adv > 0) begin
            m_timer += adv;
            if (m_timer >= m_rec_len) go_idle();
          end
        end
      end
      default: begin
        if (top == 5) begin
          if (m_resume == 3) m_rec_len = m_timer;
          go_idle();
        end else if (top == 4 || top == 2) begin
          m_mode = m_resume;
          if (m_resume == 2) m_slow = 0;
        end
      end
    endcase
    if (old_mode != 3 && (top == 1 || top == 0)) begin
      m_slow = 0;
      if (top == 1) m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
      else          m_level = (m_level - 1 < -7) ? -7 : m_level - 1;
    end
  endtask

  task automatic cycle(input logic [5:0] k);
    @(negedge clk);
    {k_stop, k_pause, k_rec, k_play, k_fast, k_slow} = k;
    model_step(k);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(6'b0);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(o_state), 1);
    chk({tag, "_timer"}, int'(o_timer), 0);
    chk({tag, "_stat"},  int'(o_speed_stat), 0);
    chk({tag, "_speed"}, int'(o_speed), 1);
    chk({tag, "_rec_en"}, int'(o_rec_en), 0);
    chk({tag, "_play_en"}, int'(o_play_en), 0);
  endtask

  // Monitor: one expected observation per driven cycle, compared after the edge.
  always @(posedge clk) begin
    obs_t a, e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{o_state, o_timer, o_speed_stat, o_speed, o_rec_en, o_play_en};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t got st=%0d tm=%0d ss=%0d sp=%0d re=%0b pe=%0b expected st=%0d tm=%0d ss=%0d sp=%0d re=%0b pe=%0b",
                 $time, a.st, a.tm, a.ss, a.sp, a.re, a.pe, e.st, e.tm, e.ss, e.sp, e.re, e.pe);
      end
    end
  end

  initial begin
    logic [5:0] k;
    int         wait_n;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // 1: full-length recording auto-stops at MAX_SEC
    cycle(KB_REC);
    idle(35 * CPS);
    chk("t1_state", int'(o_state), 1);
    chk("t1_timer", int'(o_timer), 0);

    // 2: record 5 s then play it back
    cycle(KB_REC); idle(5 * CPS + 3); cycle(KB_STOP);
    cycle(KB_PLAY); idle(2);
    chk("t2_play", int'(o_state), 2);
    idle(6 * CPS);
    chk("t2_end", int'(o_state), 1);

    // 3: fast x4 with rec_len=10 saturates at the end
    for (int i = 0; i < 3; i++) cycle(KB_FAST);
    idle(2);
    chk("t3_speed", int'(o_speed), 4);
    chk("t3_stat", int'(o_speed_stat), 1);
    cycle(KB_REC); idle(10 * CPS + 4); cycle(KB_STOP);
    cycle(KB_PLAY); idle(4 * CPS);
    chk("t3_end", int'(o_state), 1);

    // 4: slow x3, then slow saturates at 8, then back to normal
    for (int i = 0; i < 5; i++) cycle(KB_SLOW);
    idle(2);
    chk("t4_stat", int'(o_speed_stat), 2);
    chk("t4_speed", int'(o_speed), 3);
    cycle(KB_PLAY); idle(10 * CPS); cycle(KB_STOP);
    for (int i = 0; i < 7; i++) cycle(KB_SLOW);
    idle(2);
    chk("t4_sat", int'(o_speed), 8);
    for (int i = 0; i < 7; i++) cycle(KB_FAST);
    idle(2);
    chk("t4_norm_stat", int'(o_speed_stat), 0);
    chk("t4_norm_speed", int'(o_speed), 1);

    // 5: pause during playback holds timer and state
    cycle(KB_PLAY);
    wait_n = 0;
    while (o_timer != 5'd3 && wait_n < 300) begin idle(1); wait_n++; end
    chk("t5_reach3", int'(o_timer), 3);
    cycle(KB_PAUSE); idle(10 * CPS);
    chk("t5_pstate", int'(o_state), 4);
    chk("t5_ptimer", int'(o_timer), 3);
    cycle(KB_PAUSE); idle(2);
    chk("t5_resume", int'(o_state), 2);
    idle(2 * CPS); cycle(KB_STOP);

    // 6: stop beats pause; then async reset mid-play
    cycle(KB_REC); idle(2 * CPS + 5);
    cycle(KB_STOP | KB_PAUSE); idle(2);
    chk("t6_stoppause", int'(o_state), 1);
    cycle(KB_PLAY); idle(5);
    chk("t6_playing", int'(o_state), 2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cycle(KB_PLAY); idle(2);
    chk("t6_nolen", int'(o_state), 1);

    // Random traffic against the model
    for (int n = 0; n < 6000; n++) begin
      k = 6'b0;
      if ($urandom_range(0, 149) == 0) k[5] = 1'b1;
      if ($urandom_range(0, 89)  == 0) k[4] = 1'b1;
      if ($urandom_range(0, 59)  == 0) k[3] = 1'b1;
      if ($urandom_range(0, 39)  == 0) k[2] = 1'b1;
      if ($urandom_range(0, 69)  == 0) k[1] = 1'b1;
      if ($urandom_range(0, 69)  == 0) k[0] = 1'b1;
      cycle(k);
    end
    idle(1);

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 10) begin @(negedge clk); wait_n++; end
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
